awg_status_tx: RTL and testbench
================================

// Module: awg_status_tx
// PURPOSE
//  Transmit-side telemetry framer for the FT232H 245-FIFO link. The receive path carries
//  host commands into the AWG core; this block drives the bridge's 8-bit tx AXI-stream
//  (tx_tvalid/tready/tdata/tkeep/tlast) with fixed 14-byte status frames.
//  Frames are sent on host request, on a periodic timer, or both. Sits beside the AWG core
//  in clk100 and replaces the tied-off tx inputs of the FTDI bridge.
// PARAMETERS
//  STATUS_PERIOD  0      clk100 cycles between automatic frames; 0 disables the timer
//  SYNC_BYTE      8'hA5  first byte of every frame
// PORTS
//  clk100       in   1   system clock, 100 MHz
//  rstn_async   in   1   asynchronous active-low reset
//  report_req   in   1   single-cycle request for one frame
//  trigger      in   1   trigger input, already synchronous to clk100
//  awg_valid    in   1   AWG core sample-valid
//  err_latched  in   1   AWG core sticky error
//  pll_locked   in   2   {pll_12_locked, pll_100_locked}
//  fifo_level   in   16  current rx FIFO occupancy, in bytes
//  tx_tready    in   1   bridge ready
//  tx_tvalid    out  1   frame byte valid
//  tx_tdata     out  8   frame byte
//  tx_tkeep     out  1   equals tx_tvalid
//  tx_tlast     out  1   high on the checksum byte (byte 13) only
//  busy         out  1   frame in flight or request pending
//  req_dropped  out  1   one-cycle pulse when a request is discarded
// BEHAVIOUR
//  Reset: all outputs 0. Counters, seq, pending, timer and state cleared immediately (async).
//  Reset mid-frame truncates the frame. The host resyncs on SYNC_BYTE plus a checksum check.
//  Counters, always running:
//   - trig_cnt[31:0]: +1 on each rising edge of trigger (registered edge detect), wraps.
//   - samp_cnt[31:0]: +1 each cycle awg_valid=1, wraps.
//  Timer (STATUS_PERIOD>0): counts 0..STATUS_PERIOD-1. Reaching the terminal count raises an
//   internal request that cycle, then the count restarts at 0.
//  Requests: report_req OR timer request sets pending.
//   - Manual and timer request in the same cycle count as one request.
//   - A request arriving while pending=1 is discarded with req_dropped=1 for one cycle.
//   - A request during SEND with pending=0 sets pending. That frame follows the current one.
//  FSM IDLE -> SEND -> IDLE:
//   - IDLE with pending=1: snapshot the status into frame registers, clear pending, idx<=0,
//     go to SEND. tx_tvalid=1 on the next cycle, so latency from req to tvalid is 2 cycles.
//   - A request seen in IDLE with pending=0 is captured the same cycle. In that case the
//     frame starts 1 cycle later.
//   - SEND: byte idx presented. On tvalid&tready, idx+1 and running sum += tdata.
//   - tdata/tlast stay stable while tvalid & !tready; tvalid never drops mid-frame.
//   - Accepting byte 13: go to IDLE, seq+1 (8-bit, wraps 255->0), tvalid=0 next cycle.
//   - Frames are back-to-back at most; IDLE always lasts >= 1 cycle between frames.
//  Frame layout (multi-byte fields little-endian, taken from the snapshot):
//   - 0: SYNC_BYTE
//   - 1: seq
//   - 2: {4'b0, awg_valid, pll_locked[1:0], err_latched}
//   - 3-6: trig_cnt
//   - 7-8: fifo_level
//   - 9-12: samp_cnt
//   - 13: checksum = -(sum of bytes 0..12) mod 256, so bytes 0..13 sum to 8'h00
//  busy = (state==SEND) | pending.
// TESTING
//  1 Reset, then one report_req, tready=1 -> tvalid at +2 cycles, 14 bytes, tlast only on
//    byte 13. Bytes = A5 00 flags 00000000 level 00000000 cks. Sum of all bytes = 00.
//  2 3 trigger pulses + 100 awg_valid cycles, then a request -> bytes 3-6 = 03 00 00 00,
//    bytes 9-12 = 64 00 00 00.
//  3 Random tready backpressure (~50%) -> tdata/tlast hold while stalled, no byte lost or
//    repeated, checksum correct.
//  4 Requests at frame start, mid-frame and again mid-frame -> 2 frames (seq 0, 1) and
//    exactly one req_dropped pulse.
//  5 STATUS_PERIOD=64, tready=1 -> a frame every 64 cycles. Seq wraps FF->00 after 256 frames.
//  6 rstn_async low at byte 7 -> tvalid/tlast/busy drop at once. Next frame after release
//    has seq=00 and zero counters.

Source files
------------

// File: rtl/awg_status_tx_if.sv
// awg_status_tx_if
//  Byte-wide AXI-stream carrying status frames from awg_status_tx to the FTDI
//  bridge transmit path.
//  Signals:
//   tx_tvalid  frame byte valid (source)
//   tx_tready  bridge ready (sink)
//   tx_tdata   frame byte (source)
//   tx_tkeep   byte qualifier, equal to tx_tvalid (source)
//   tx_tlast   marks the final byte of a frame (source)
//  Handshake: a byte moves on every rising clock edge where tx_tvalid and
//  tx_tready are both high. Once tx_tvalid is raised, the source holds it and
//  keeps tx_tdata/tx_tkeep/tx_tlast unchanged until that edge. It never waits
//  for tx_tready before raising tx_tvalid. The sink may toggle tx_tready freely.
interface awg_status_tx_if;
  logic       tx_tvalid;
  logic       tx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tkeep;
  logic       tx_tlast;

  modport master (
    output tx_tvalid,
    output tx_tdata,
    output tx_tkeep,
    output tx_tlast,
    input  tx_tready
  );

  modport slave (
    input  tx_tvalid,
    input  tx_tdata,
    input  tx_tkeep,
    input  tx_tlast,
    output tx_tready
  );
endinterface

// File: rtl/awg_status_tx.sv
// awg_status_tx
//  Telemetry framer for the FT232H transmit path. It sends a fixed 14-byte
//  status frame on a host request, on a periodic timer, or on both:
//   0 SYNC_BYTE, 1 seq, 2 flags {4'b0, awg_valid, pll_locked, err_latched},
//   3-6 trig_cnt, 7-8 fifo_level, 9-12 samp_cnt (little-endian), 13 checksum.
//  The checksum makes the 14 bytes sum to 8'h00.
//  Ports:
//   clk100, rstn_async    clock and asynchronous active-low reset
//   report_req            single-cycle frame request
//   trigger, awg_valid    sources of the trigger-edge and sample counters
//   err_latched,
//   pll_locked,
//   fifo_level            status fields captured when a frame starts
//   tx                    byte stream towards the bridge (master side)
//   busy                  a frame is in flight or a request is pending
//   req_dropped           one-cycle pulse when a request is discarded
module awg_status_tx #(
  parameter int unsigned STATUS_PERIOD = 0,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
  input  logic            clk100,
  input  logic            rstn_async,
  input  logic            report_req,
  input  logic            trigger,
  input  logic            awg_valid,
  input  logic            err_latched,
  input  logic [1:0]      pll_locked,
  input  logic [15:0]     fifo_level,
  awg_status_tx_if.master tx,
  output logic            busy,
  output logic            req_dropped
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_e;

  localparam bit          TIMER_EN   = (STATUS_PERIOD != 0);
  localparam logic [31:0] TIMER_LAST = TIMER_EN ? 32'(STATUS_PERIOD - 1) : 32'd0;
  localparam logic [3:0]  LAST_IDX   = 4'd13;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic        req_dropped_q, req_dropped_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  seq_q, seq_d;
  logic        trig_prev_q, trig_prev_d;
  logic [31:0] trig_cnt_q, trig_cnt_d;
  logic [31:0] samp_cnt_q, samp_cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  snap_flags_q, snap_flags_d;
  logic [31:0] snap_trig_q, snap_trig_d;
  logic [15:0] snap_level_q, snap_level_d;
  logic [31:0] snap_samp_q, snap_samp_d;

  logic       timer_req;
  logic       req_any;
  logic       start;
  logic       accept;
  logic       sending;
  logic [7:0] frame_byte;

  // State register
  always_ff @(posedge clk100 or negedge rstn_async) begin
    if (!rstn_async) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pending_q) state_d = ST_SEND;
      ST_SEND: if (tx.tx_tready && (idx_q == LAST_IDX)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: byte selection from the snapshot taken at frame start
  always_comb begin
    sending = (state_q == ST_SEND);
    case (idx_q)
      4'd0:    frame_byte = SYNC_BYTE;
      4'd1:    frame_byte = seq_q;
      4'd2:    frame_byte = snap_flags_q;
      4'd3:    frame_byte = snap_trig_q[7:0];
      4'd4:    frame_byte = snap_trig_q[15:8];
      4'd5:    frame_byte = snap_trig_q[23:16];
      4'd6:    frame_byte = snap_trig_q[31:24];
      4'd7:    frame_byte = snap_level_q[7:0];
      4'd8:    frame_byte = snap_level_q[15:8];
      4'd9:    frame_byte = snap_samp_q[7:0];
      4'd10:   frame_byte = snap_samp_q[15:8];
      4'd11:   frame_byte = snap_samp_q[23:16];
      4'd12:   frame_byte = snap_samp_q[31:24];
      // sum_q holds bytes 0..12 by the time byte 13 is presented
      4'd13:   frame_byte = 8'd0 - sum_q;
      default: frame_byte = 8'd0;
    endcase
    tx.tx_tvalid = sending;
    tx.tx_tkeep  = sending;
    tx.tx_tdata  = sending ? frame_byte : 8'd0;
    tx.tx_tlast  = sending && (idx_q == LAST_IDX);
    busy         = sending | pending_q;
    req_dropped  = req_dropped_q;
  end

  // Datapath: counters, timer, request capture, frame progress
  always_comb begin
    trig_prev_d = trigger;
    trig_cnt_d  = trig_cnt_q + ((trigger && !trig_prev_q) ? 32'd1 : 32'd0);
    samp_cnt_d  = samp_cnt_q + (awg_valid ? 32'd1 : 32'd0);

    timer_d   = 32'd0;
    timer_req = 1'b0;
    if (TIMER_EN) begin
      if (timer_q == TIMER_LAST) timer_req = 1'b1;
      else                       timer_d   = timer_q + 32'd1;
    end

    // Manual and timer requests in one cycle merge into a single request
    req_any = report_req | timer_req;
    start   = (state_q == ST_IDLE) && pending_q;
    accept  = (state_q == ST_SEND) && tx.tx_tready;

    // Only one request can be queued; pending_q is judged before this
    // cycle's start clears it, so a request on the start cycle is dropped.
    pending_d     = pending_q;
    req_dropped_d = 1'b0;
    if (start) pending_d = 1'b0;
    if (req_any) begin
      if (pending_q) req_dropped_d = 1'b1;
      else           pending_d     = 1'b1;
    end

    idx_d        = idx_q;
    sum_d        = sum_q;
    seq_d        = seq_q;
    snap_flags_d = snap_flags_q;
    snap_trig_d  = snap_trig_q;
    snap_level_d = snap_level_q;
    snap_samp_d  = snap_samp_q;
    if (start) begin
      idx_d        = 4'd0;
      sum_d        = 8'd0;
      snap_flags_d = {4'b0000, awg_valid, pll_locked, err_latched};
      snap_trig_d  = trig_cnt_q;
      snap_level_d = fifo_level;
      snap_samp_d  = samp_cnt_q;
    end else if (accept) begin
      sum_d = sum_q + frame_byte;
      if (idx_q == LAST_IDX) begin
        idx_d = 4'd0;
        seq_d = seq_q + 8'd1;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk100 or negedge rstn_async) begin
    if (!rstn_async) begin
      pending_q     <= 1'b0;
      req_dropped_q <= 1'b0;
      idx_q         <= 4'd0;
      sum_q         <= 8'd0;
      seq_q         <= 8'd0;
      trig_prev_q   <= 1'b0;
      trig_cnt_q    <= 32'd0;
      samp_cnt_q    <= 32'd0;
      timer_q       <= 32'd0;
      snap_flags_q  <= 8'd0;
      snap_trig_q   <= 32'd0;
      snap_level_q  <= 16'd0;
      snap_samp_q   <= 32'd0;
    end else begin
      pending_q     <= pending_d;
      req_dropped_q <= req_dropped_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      seq_q         <= seq_d;
      trig_prev_q   <= trig_prev_d;
      trig_cnt_q    <= trig_cnt_d;
      samp_cnt_q    <= samp_cnt_d;
      timer_q       <= timer_d;
      snap_flags_q  <= snap_flags_d;
      snap_trig_q   <= snap_trig_d;
      snap_level_q  <= snap_level_d;
      snap_samp_q   <= snap_samp_d;
    end
  end

endmodule

// File: tb/tb_awg_status_tx.sv
`timescale 1ns/1ps
module tb_awg_status_tx;

  // ---------------- clock / reset ----------------
  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic        rstn_async, report_req, trigger, awg_valid, err_latched;
  logic [1:0]  pll_locked;
  logic [15:0] fifo_level;
  logic        busy, req_dropped;
  awg_status_tx_if tx_if();

  awg_status_tx #(.STATUS_PERIOD(0), .SYNC_BYTE(8'hA5)) dut (
    .clk100(clk100), .rstn_async(rstn_async), .report_req(report_req),
    .trigger(trigger), .awg_valid(awg_valid), .err_latched(err_latched),
    .pll_locked(pll_locked), .fifo_level(fifo_level), .tx(tx_if),
    .busy(busy), .req_dropped(req_dropped));

  // Second instance with the periodic timer enabled
  logic        rstn_t, report_req_t, trigger_t, awg_valid_t, err_t;
  logic [1:0]  pll_t;
  logic [15:0] level_t;
  logic        busy_t, req_dropped_t;
  awg_status_tx_if tx_t_if();

  awg_status_tx #(.STATUS_PERIOD(64), .SYNC_BYTE(8'hA5)) dut_t (
    .clk100(clk100), .rstn_async(rstn_t), .report_req(report_req_t),
    .trigger(trigger_t), .awg_valid(awg_valid_t), .err_latched(err_t),
    .pll_locked(pll_t), .fifo_level(level_t), .tx(tx_t_if),
    .busy(busy_t), .req_dropped(req_dropped_t));

  // ---------------- bookkeeping ----------------
  int      vec_cnt = 0;
  int      miscompares = 0;
  longint  cyc = 0;
  int      drop_cnt = 0;

  always @(posedge clk100) cyc <= cyc + 1;
  always @(negedge clk100) if (req_dropped === 1'b1) drop_cnt <= drop_cnt + 1;

  // Reference model state
  logic [7:0]  m_seq;
  logic [31:0] m_trig, m_samp;

  // Scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  bit         obs_last_q[$];
  int         stall_err, valid_drop, cap_wait;
  bit         cap_timeout;

  // Frame content from the field layout; checksum is the two's complement of the byte sum
  task automatic build_expected(input logic [7:0] seq, input logic [7:0] flags,
                                input logic [31:0] trig, input logic [15:0] level,
                                input logic [31:0] samp);
    logic [7:0] s;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    exp_q.push_back(flags);
    for (int i = 0; i < 4; i++) exp_q.push_back(trig[8*i +: 8]);
    for (int i = 0; i < 2; i++) exp_q.push_back(level[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(samp[8*i +: 8]);
    s = 8'd0;
    foreach (exp_q[i]) s = s + exp_q[i];
    exp_q.push_back(8'd0 - s);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_request();
    report_req = 1'b1;
    @(negedge clk100);
    report_req = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk100);
    trigger = 1'b0;
    @(negedge clk100);
    m_trig = m_trig + 32'd1;
  endtask

  task automatic valid_cycles(input int n);
    awg_valid = 1'b1;
    repeat (n) @(negedge clk100);
    awg_valid = 1'b0;
    m_samp = m_samp + 32'(n);
  endtask

  // Records one frame from the main instance with random tready
  task automatic capture_frame(input int ready_pct, input int max_cyc);
    int n;
    logic [7:0] held_d;
    logic held_l;
    bit stalled;
    obs_q.delete(); obs_last_q.delete();
    stall_err = 0; valid_drop = 0; cap_timeout = 0; cap_wait = 0;
    stalled = 0; n = 0; held_d = 8'd0; held_l = 1'b0;
    while (tx_if.tx_tvalid !== 1'b1 && n < max_cyc) begin
      @(negedge clk100); n++;
    end
    cap_wait = n;
    if (tx_if.tx_tvalid !== 1'b1) begin cap_timeout = 1; return; end
    forever begin
      if (n >= max_cyc) begin cap_timeout = 1; break; end
      if (tx_if.tx_tvalid !== 1'b1) valid_drop++;
      if (tx_if.tx_tkeep !== tx_if.tx_tvalid) valid_drop++;
      if (stalled && (tx_if.tx_tdata !== held_d || tx_if.tx_tlast !== held_l)) stall_err++;
      tx_if.tx_tready = ($urandom_range(0, 99) < ready_pct);
      if (tx_if.tx_tvalid === 1'b1 && tx_if.tx_tready) begin
        obs_q.push_back(tx_if.tx_tdata);
        obs_last_q.push_back(tx_if.tx_tlast);
        stalled = 0;
        if (tx_if.tx_tlast === 1'b1) begin @(negedge clk100); break; end
      end else begin
        stalled = (tx_if.tx_tvalid === 1'b1);
        held_d  = tx_if.tx_tdata;
        held_l  = tx_if.tx_tlast;
      end
      @(negedge clk100); n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn_async = 1'b0; rstn_t = 1'b0;
    report_req = 0; trigger = 0; awg_valid = 0; err_latched = 0;
    pll_locked = 2'b00; fifo_level = 16'h0000; tx_if.tx_tready = 1'b0;
    report_req_t = 0; trigger_t = 0; awg_valid_t = 0; err_t = 1'b1;
    pll_t = 2'b01; level_t = 16'hBEEF; tx_t_if.tx_tready = 1'b1;
    m_seq = 8'd0; m_trig = 32'd0; m_samp = 32'd0;
    repeat (3) @(negedge clk100);
    vec_cnt++; if (tx_if.tx_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b want 0", tx_if.tx_tvalid); end
    vec_cnt++; if (tx_if.tx_tdata !== 8'h00) begin miscompares++; $display("FAIL rst_tdata: got %h want 00", tx_if.tx_tdata); end
    vec_cnt++; if (tx_if.tx_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast: got %b want 0", tx_if.tx_tlast); end
    vec_cnt++; if (tx_if.tx_tkeep !== 1'b0) begin miscompares++; $display("FAIL rst_tkeep: got %b want 0", tx_if.tx_tkeep); end
    vec_cnt++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec_cnt++; if (req_dropped !== 1'b0) begin miscompares++; $display("FAIL rst_drop: got %b want 0", req_dropped); end
    rstn_async = 1'b1;
    repeat (2) @(negedge clk100);
    vec_cnt++; if (tx_if.tx_tvalid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: tvalid=%b busy=%b want 0 0", tx_if.tx_tvalid, busy); end
  endtask

  task automatic test_single_frame();
    logic [7:0] s;
    pll_locked = 2'b11; err_latched = 1'b0; fifo_level = 16'h0010;
    tx_if.tx_tready = 1'b1;
    build_expected(m_seq, {4'b0, 1'b0, pll_locked, err_latched}, m_trig, fifo_level, m_samp);
    do_request();
    vec_cnt++; if (tx_if.tx_tvalid !== 1'b0) begin miscompares++; $display("FAIL t1_early: tvalid=%b want 0 one cycle after request", tx_if.tx_tvalid); end
    vec_cnt++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t1_busy_pend: got %b want 1", busy); end
    @(negedge clk100);
    vec_cnt++; if (tx_if.tx_tvalid !== 1'b1) begin miscompares++; $display("FAIL t1_latency: tvalid=%b want 1 two cycles after request", tx_if.tx_tvalid); end
    capture_frame(100, 200);
    vec_cnt++; if (cap_timeout || obs_q.size() != 14) begin miscompares++; $display("FAIL t1_len: got %0d bytes timeout=%0d want 14", obs_q.size(), cap_timeout); end
    s = 8'd0;
    for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
      vec_cnt++; s = s + obs_q[i];
      if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== (i == 13)) begin
        miscompares++; $display("FAIL t1_byte%0d: got %h last=%0b want %h last=%0b", i, obs_q[i], obs_last_q[i], exp_q[i], (i == 13));
      end
    end
    vec_cnt++; if (s !== 8'h00) begin miscompares++; $display("FAIL t1_sum: got %h want 00", s); end
    vec_cnt++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t1_busy_end: got %b want 0", busy); end
    m_seq = m_seq + 8'd1;
  endtask

  task automatic test_counters();
    longint c0;
    repeat (3) pulse_trigger();
    valid_cycles(100);
    pll_locked = 2'b01; err_latched = 1'b1; fifo_level = 16'h1234;
    build_expected(m_seq, {4'b0, 1'b0, pll_locked, err_latched}, m_trig, fifo_level, m_samp);
    do_request();
    capture_frame(100, 200);
    vec_cnt++; if (cap_timeout || obs_q.size() != 14) begin miscompares++; $display("FAIL t2_len: got %0d bytes timeout=%0d want 14", obs_q.size(), cap_timeout); end
    for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL t2_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    m_seq = m_seq + 8'd1;
    // awg_valid held high across the request: the snapshot sees one extra sample
    c0 = cyc;
    awg_valid = 1'b1;
    build_expected(m_seq, {4'b0, 1'b1, pll_locked, err_latched}, m_trig, fifo_level, m_samp + 32'd1);
    do_request();
    capture_frame(100, 200);
    awg_valid = 1'b0;
    m_samp = m_samp + 32'(cyc - c0);
    vec_cnt++; if (cap_timeout || obs_q.size() != 14) begin miscompares++; $display("FAIL t2b_len: got %0d bytes want 14", obs_q.size()); end
    for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL t2b_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    m_seq = m_seq + 8'd1;
  endtask

  task automatic test_backpressure();
    logic [7:0] s;
    for (int f = 0; f < 4; f++) begin
      err_latched = 1'($urandom_range(0, 1));
      pll_locked  = 2'($urandom_range(0, 3));
      fifo_level  = 16'($urandom);
      build_expected(m_seq, {4'b0, 1'b0, pll_locked, err_latched}, m_trig, fifo_level, m_samp);
      do_request();
      capture_frame(50, 400);
      vec_cnt++; if (cap_timeout || obs_q.size() != 14) begin miscompares++; $display("FAIL t3_len f%0d: got %0d bytes timeout=%0d want 14", f, obs_q.size(), cap_timeout); end
      vec_cnt++; if (stall_err != 0) begin miscompares++; $display("FAIL t3_hold f%0d: %0d changes while stalled want 0", f, stall_err); end
      vec_cnt++; if (valid_drop != 0) begin miscompares++; $display("FAIL t3_valid f%0d: %0d tvalid/tkeep drops want 0", f, valid_drop); end
      s = 8'd0;
      for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
        vec_cnt++; s = s + obs_q[i];
        if (obs_q[i] !== exp_q[i] || obs_last_q[i] !== (i == 13)) begin
          miscompares++; $display("FAIL t3_byte f%0d b%0d: got %h last=%0b want %h last=%0b", f, i, obs_q[i], obs_last_q[i], exp_q[i], (i == 13));
        end
      end
      vec_cnt++; if (s !== 8'h00) begin miscompares++; $display("FAIL t3_sum f%0d: got %h want 00", f, s); end
      m_seq = m_seq + 8'd1;
    end
    tx_if.tx_tready = 1'b1;
  endtask

  task automatic test_back_to_back();
    int d0, quiet;
    d0 = drop_cnt;
    tx_if.tx_tready = 1'b1;
    pll_locked = 2'b10; err_latched = 1'b0; fifo_level = 16'h00FF;
    do_request();
    fork
      begin
        build_expected(m_seq, {4'b0, 1'b0, pll_locked, err_latched}, m_trig, fifo_level, m_samp);
        capture_frame(100, 200);
        vec_cnt++; if (cap_timeout || obs_q.size() != 14) begin miscompares++; $display("FAIL t4a_len: got %0d bytes want 14", obs_q.size()); end
        for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
          vec_cnt++;
          if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL t4a_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        build_expected(m_seq + 8'd1, {4'b0, 1'b0, pll_locked, err_latched}, m_trig, fifo_level, m_samp);
        capture_frame(100, 200);
        vec_cnt++; if (cap_wait != 1) begin miscompares++; $display("FAIL t4_gap: idle cycles %0d want 1", cap_wait); end
        vec_cnt++; if (cap_timeout || obs_q.size() != 14) begin miscompares++; $display("FAIL t4b_len: got %0d bytes want 14", obs_q.size()); end
        for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
          vec_cnt++;
          if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL t4b_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
      end
      begin
        repeat (6) @(negedge clk100);
        do_request();
        repeat (2) @(negedge clk100);
        do_request();
      end
    join
    m_seq = m_seq + 8'd2;
    quiet = 0;
    repeat (20) begin
      @(negedge clk100);
      if (tx_if.tx_tvalid !== 1'b0) quiet++;
    end
    vec_cnt++; if (quiet != 0) begin miscompares++; $display("FAIL t4_extra: tvalid high %0d cycles after 2 frames want 0", quiet); end
    vec_cnt++; if (drop_cnt - d0 != 1) begin miscompares++; $display("FAIL t4_drops: got %0d pulses want 1", drop_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    int k, n;
    tx_if.tx_tready = 1'b1;
    pulse_trigger();
    valid_cycles(5);
    do_request();
    k = 0; n = 0;
    while (k < 7 && n < 100) begin
      if (tx_if.tx_tvalid === 1'b1) k++;
      @(negedge clk100); n++;
    end
    vec_cnt++; if (k != 7) begin miscompares++; $display("FAIL t6_reach: got %0d bytes want 7", k); end
    rstn_async = 1'b0;
    #1;
    vec_cnt++; if (tx_if.tx_tvalid !== 1'b0 || tx_if.tx_tlast !== 1'b0) begin miscompares++; $display("FAIL t6_drop: tvalid=%b tlast=%b want 0 0", tx_if.tx_tvalid, tx_if.tx_tlast); end
    vec_cnt++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t6_busy: got %b want 0", busy); end
    @(negedge clk100);
    rstn_async = 1'b1;
    m_seq = 8'd0; m_trig = 32'd0; m_samp = 32'd0;
    @(negedge clk100);
    pll_locked = 2'b11; err_latched = 1'b1; fifo_level = 16'h0042;
    build_expected(m_seq, {4'b0, 1'b0, pll_locked, err_latched}, m_trig, fifo_level, m_samp);
    do_request();
    capture_frame(100, 200);
    vec_cnt++; if (cap_timeout || obs_q.size() != 14) begin miscompares++; $display("FAIL t6_len: got %0d bytes want 14", obs_q.size()); end
    for (int i = 0; i < 14 && i < obs_q.size(); i++) begin
      vec_cnt++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL t6_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    m_seq = m_seq + 8'd1;
  endtask

  task automatic test_timer_wrap();
    longint prev_start, start;
    int waited;
    prev_start = 0;
    rstn_t = 1'b1;
    for (int f = 0; f <= 256; f++) begin
      waited = 0;
      while (tx_t_if.tx_tvalid !== 1'b1 && waited < 100) begin
        @(negedge clk100); waited++;
      end
      vec_cnt++;
      if (tx_t_if.tx_tvalid !== 1'b1) begin
        miscompares++; $display("FAIL t5_timeout: frame %0d never started", f);
        break;
      end
      start = cyc;
      if (f > 0) begin
        vec_cnt++;
        if (start - prev_start != 64) begin miscompares++; $display("FAIL t5_period f%0d: got %0d cycles want 64", f, start - prev_start); end
      end
      prev_start = start;
      build_expected(8'(f), {4'b0, awg_valid_t, pll_t, err_t}, 32'd0, level_t, 32'd0);
      for (int i = 0; i < 14; i++) begin
        vec_cnt++;
        if (tx_t_if.tx_tvalid !== 1'b1 || tx_t_if.tx_tdata !== exp_q[i] || tx_t_if.tx_tlast !== (i == 13)) begin
          miscompares++; $display("FAIL t5_byte f%0d b%0d: got v=%b %h last=%b want v=1 %h last=%0b", f, i, tx_t_if.tx_tvalid, tx_t_if.tx_tdata, tx_t_if.tx_tlast, exp_q[i], (i == 13));
        end
        @(negedge clk100);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_counters();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_timer_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
